// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the 1:N stream demultiplexer.
package stream_demux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Field width able to index n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready output register; data reads as zero whenever empty.
module demux_lane_reg #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] ld_data,
  input  logic            ready,
  output logic            valid,
  output logic [BITS-1:0] data
);

  // A load wins over a drain in the same cycle, so back-to-back beats leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1:N stream demux with explicit-select and burst round-robin routing.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int NUM_OUT   = 4,
  parameter int SEL_W     = sel_width(NUM_OUT),
  parameter int BURST_LEN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS-1:0]         in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_OUT-1:0]      out_valid,
  input  logic [NUM_OUT-1:0]      out_ready,
  output logic [NUM_OUT*BITS-1:0] out_data,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic                    err_drop
);

  localparam int                CNT_W    = sel_width(BURST_LEN);
  localparam logic [SEL_W-1:0]  PTR_LAST = SEL_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [SEL_W:0]    NUM_LIM  = (SEL_W+1)'(NUM_OUT);

  logic [CNT_W-1:0]   burst_cnt;
  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               accept;
  logic [NUM_OUT-1:0] lane_free;
  logic [NUM_OUT-1:0] load;

  assign tgt       = (mode == MODE_RR) ? rr_ptr : in_sel;
  assign tgt_ok    = ({1'b0, tgt} < NUM_LIM);
  assign lane_free = ~out_valid | out_ready;
  // Out-of-range selects are always accepted so the producer never deadlocks on them.
  assign in_ready  = tgt_ok ? lane_free[tgt] : 1'b1;
  assign accept    = in_valid & in_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign load[k] = accept & tgt_ok & (tgt == SEL_W'(k));

    demux_lane_reg #(.BITS(BITS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (load[k]),
      .ld_data (in_data),
      .ready   (out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*BITS +: BITS])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_drop <= 1'b0;
    else     err_drop <= accept & ~tgt_ok;
  end

  // Explicit mode parks the pointer so entering round-robin always starts at lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (mode == MODE_EXPLICIT) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      if (burst_cnt == CNT_LAST) begin
        burst_cnt <= '0;
        rr_ptr    <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + 1'b1;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: directed scenarios plus a randomized run against a queue-level model.
module tb_stream_demux_1ton;

  localparam int B  = 16;
  localparam int N  = 4;
  localparam int BL = 2;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 4 lanes, bursts of 2
  logic          mode, in_valid, in_ready, err_drop;
  logic [B-1:0]  in_data;
  logic [1:0]    in_sel, rr_ptr;
  logic [N-1:0]  out_valid, out_ready;
  logic [N*B-1:0] out_data;

  // Second instance: 3 lanes (non power of two), burst of 1
  logic           b_mode, b_in_valid, b_in_ready, b_err_drop;
  logic [B-1:0]   b_in_data;
  logic [1:0]     b_in_sel, b_rr_ptr;
  logic [N3-1:0]  b_out_valid, b_out_ready;
  logic [N3*B-1:0] b_out_data;

  int n_chk  = 0;
  int n_fail = 0;

  stream_demux_1ton #(.BITS(B), .NUM_OUT(N), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .rr_ptr(rr_ptr), .err_drop(err_drop)
  );

  stream_demux_1ton #(.BITS(B), .NUM_OUT(N3), .BURST_LEN(1)) dut3 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .rr_ptr(b_rr_ptr), .err_drop(b_err_drop)
  );

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    n_chk++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_chk++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", rr_ptr); end
    n_chk++; if (err_drop !== 1'b0 || b_err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b expected 0/0", err_drop, b_err_drop); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_explicit();
    @(negedge clk);
    mode = 1'b0; in_sel = 2'd2; in_data = 16'h1234; in_valid = 1'b1; out_ready = 4'hF;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL explicit_valid: got %b expected 0100", out_valid); end
    n_chk++; if (out_data !== 64'h0000_1234_0000_0000) begin n_fail++; $display("FAIL explicit_data: got %h expected 0000123400000000", out_data); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL explicit_drain: got %b expected 0000", out_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    mode = 1'b0; in_sel = 2'd1; in_data = 16'hAAAA; in_valid = 1'b1; out_ready = 4'b1101;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_chk++; if (out_data[B +: B] !== 16'hAAAA) begin n_fail++; $display("FAIL bp_first: got %h expected aaaa", out_data[B +: B]); end
    @(negedge clk); in_data = 16'hBBBB; #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    n_chk++; if (out_data[B +: B] !== 16'hAAAA) begin n_fail++; $display("FAIL bp_hold: got %h expected aaaa", out_data[B +: B]); end
    @(negedge clk); out_ready = 4'hF; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 4'b0010 || out_data[B +: B] !== 16'hBBBB) begin n_fail++; $display("FAIL bp_second: got %b/%h expected 0010/bbbb", out_valid, out_data[B +: B]); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_empty: got %b expected 0000", out_valid); end
  endtask

  task automatic test_round_robin();
    int lane;
    @(negedge clk); mode = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      lane = (i - 1) / BL;
      @(negedge clk); mode = 1'b1; in_valid = 1'b1; in_data = 16'(i); in_sel = 2'($urandom_range(0, 3)); #1;
      n_chk++; if (rr_ptr !== 2'(lane) || in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ptr beat %0d: got ptr %0d rdy %b expected ptr %0d rdy 1", i, rr_ptr, in_ready, lane); end
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 4'(1 << lane) || out_data[lane*B +: B] !== 16'(i)) begin n_fail++; $display("FAIL rr_route beat %0d: got %b/%h expected %b/%h", i, out_valid, out_data[lane*B +: B], 4'(1 << lane), 16'(i)); end
    end
    @(negedge clk); in_valid = 1'b0; #1;
    n_chk++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_wrap: got %0d expected 0", rr_ptr); end
  endtask

  task automatic test_rr_stall();
    @(negedge clk); mode = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
    @(negedge clk); mode = 1'b1; in_valid = 1'b1; in_data = 16'h5555; out_ready = 4'b1110;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_data = 16'h6600 + 16'(i); #1;
      n_chk++; if (in_ready !== 1'b0 || rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_stall cyc %0d: got rdy %b ptr %0d expected 0/0", i, in_ready, rr_ptr); end
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 4'b0001 || out_data[B-1:0] !== 16'h5555) begin n_fail++; $display("FAIL rr_stall_hold cyc %0d: got %b/%h expected 0001/5555", i, out_valid, out_data[B-1:0]); end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 4'hF; mode = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); mode = 1'b0; in_sel = 2'd0; in_data = 16'h0A0A; in_valid = 1'b1; out_ready = 4'h0;
    @(negedge clk); in_sel = 2'd2; in_data = 16'h0C0C;
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 4'b0101) begin n_fail++; $display("FAIL rst_mid_pre: got %b expected 0101", out_valid); end
    #2 rst = 1'b1; #1;
    n_chk++; if (out_valid !== 4'b0 || out_data !== 64'h0 || rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_mid: got %b/%h/%0d expected 0/0/0", out_valid, out_data, rr_ptr); end
    @(negedge clk); rst = 1'b0; out_ready = 4'hF; mode = 1'b1; in_valid = 1'b1; in_data = 16'h1111; #1;
    n_chk++; if (in_ready !== 1'b1 || rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_mid_rdy: got %b/%0d expected 1/0", in_ready, rr_ptr); end
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 4'b0001 || out_data[B-1:0] !== 16'h1111) begin n_fail++; $display("FAIL rst_mid_first: got %b/%h expected 0001/1111", out_valid, out_data[B-1:0]); end
    @(negedge clk); in_valid = 1'b0; mode = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_invalid_sel();
    @(negedge clk); b_mode = 1'b0; b_in_sel = 2'd3; b_in_data = 16'hDEAD; b_in_valid = 1'b1; b_out_ready = 3'b111; #1;
    n_chk++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready: got %b expected 1", b_in_ready); end
    @(posedge clk); #1;
    n_chk++; if (b_err_drop !== 1'b1 || b_out_valid !== 3'b000) begin n_fail++; $display("FAIL inv_drop: got err %b vld %b expected 1/000", b_err_drop, b_out_valid); end
    @(negedge clk); b_in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (b_err_drop !== 1'b0 || b_out_data !== 48'h0) begin n_fail++; $display("FAIL inv_pulse: got err %b data %h expected 0/0", b_err_drop, b_out_data); end
  endtask

  task automatic test_rr_burst1();
    for (int i = 0; i < N3; i++) begin
      @(negedge clk); b_mode = 1'b1; b_in_valid = 1'b1; b_in_data = 16'hB000 + 16'(i); #1;
      n_chk++; if (b_rr_ptr !== 2'(i)) begin n_fail++; $display("FAIL b1_ptr beat %0d: got %0d expected %0d", i, b_rr_ptr, i); end
      @(posedge clk); #1;
      n_chk++; if (b_out_valid !== 3'(1 << i) || b_out_data[i*B +: B] !== 16'hB000 + 16'(i)) begin n_fail++; $display("FAIL b1_route beat %0d: got %b/%h expected %b/%h", i, b_out_valid, b_out_data[i*B +: B], 3'(1 << i), 16'hB000 + 16'(i)); end
    end
    @(negedge clk); b_in_valid = 1'b0; #1;
    n_chk++; if (b_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL b1_wrap: got %0d expected 0", b_rr_ptr); end
    b_mode = 1'b0;
  endtask

  // Model: per-lane holding slot plus a count of round-robin accepts since the last explicit cycle.
  task automatic test_random(input int cycles);
    logic           mv[N];
    logic [B-1:0]   md[N];
    int             rr_acc, t, exp_ptr;
    logic           exp_rdy, exp_err, acc;
    logic [N-1:0]   exp_vld;
    logic [N*B-1:0] exp_data;
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; mode = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < N; k++) begin mv[k] = 1'b0; md[k] = '0; end
    rr_acc = 0; exp_err = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      in_sel    = 2'($urandom_range(0, 3));
      out_ready = 4'($urandom | $urandom);
      #1;
      exp_ptr = (rr_acc / BL) % N;
      t       = mode ? exp_ptr : int'(in_sel);
      exp_rdy = (t >= N) ? 1'b1 : (!mv[t] || out_ready[t]);
      n_chk++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %b expected %b", c, in_ready, exp_rdy); end
      n_chk++; if (rr_ptr !== 2'(exp_ptr)) begin n_fail++; $display("FAIL rand_ptr cyc %0d: got %0d expected %0d", c, rr_ptr, exp_ptr); end
      acc = in_valid && exp_rdy;
      for (int k = 0; k < N; k++) begin
        if (acc && t == k) begin mv[k] = 1'b1; md[k] = in_data; end
        else if (mv[k] && out_ready[k]) begin mv[k] = 1'b0; md[k] = '0; end
      end
      exp_err = acc && (t >= N);
      if (!mode) rr_acc = 0;
      else if (acc) rr_acc++;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin exp_vld[k] = mv[k]; exp_data[k*B +: B] = md[k]; end
      n_chk++; if (out_valid !== exp_vld || out_data !== exp_data || err_drop !== exp_err) begin n_fail++; $display("FAIL rand_out cyc %0d: got %b/%h/%b expected %b/%h/%b", c, out_valid, out_data, err_drop, exp_vld, exp_data, exp_err); end
    end
    @(negedge clk); in_valid = 1'b0; mode = 1'b0; out_ready = 4'hF;
  endtask

  initial begin
    mode = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 4'hF;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = 3'b111;
    rst = 1'b1;
    test_reset();
    test_explicit();
    test_backpressure();
    test_round_robin();
    test_rr_stall();
    test_reset_mid();
    test_invalid_sel();
    test_rr_burst1();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
